fpu_dot_sequencer: RTL and testbench
====================================

Name: fpu_dot_sequencer

Overview:
- Control stage that sits directly upstream of the single-precision FPU multiplier and adder, and also consumes their results.
- Takes a stream of operand pairs (one matrix row element, one column element) and issues a multiply per pair.
- Chains each product through the FPU adder into a running sum, then presents the finished dot product (one output-matrix element) to the matrix-multiply controller.
- All FPU traffic uses the strobe/ack handshake of the FPU cores.

Parameters:
- MAX_LEN, 16, maximum vector length per dot product.
- LEN_W, 5, width of vec_len; must satisfy 2**LEN_W > MAX_LEN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- start  in  1  pulse: begin a dot product of vec_len elements; ignored unless busy=0.
- vec_len  in  LEN_W  element count, captured on accepted start.
- elem_a, elem_b  in  32  IEEE-754 single operands.
- elem_valid  in  1  operand pair valid.
- elem_ready  out  1  block accepts pair; transfer when elem_valid&elem_ready at posedge.
- mult_a, mult_b  out  32  to multiplier input_a/input_b.
- mult_stb  out  1  to multiplier input_stb.
- mult_ack  in  1  from multiplier input_ack.
- mult_z  in  32  multiplier output_z.
- mult_z_stb  in  1  multiplier output_stb.
- mult_z_ack  out  1  to multiplier output_ack.
- add_a, add_b, add_stb, add_ack, add_z, add_z_stb, add_z_ack: same roles and widths for the adder.
- result  out  32  finished dot product.
- result_valid  out  1  result held valid.
- result_ready  in  1  consumer accepts result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE. elem_ready, mult_stb, mult_z_ack, add_stb, add_z_ack, result_valid, busy all 0. result, mult_a/b, add_a/b, accumulator and counter all 0. Reset at any time, including mid-handshake, aborts immediately; a partial sum is discarded.
- Length handling: vec_len > MAX_LEN is clamped to MAX_LEN.
- Input handshake rule: a strobe is held with data stable until ack is sampled high at a posedge. The strobe drops the following cycle.
- Output handshake rule: when *_z_stb is sampled high, *_z is captured and *_z_ack is driven high for exactly one cycle.
- IDLE -> GET on start with vec_len != 0. Count=0.
- IDLE -> DONE on start with vec_len == 0. Accumulator=0x00000000.
- GET: elem_ready=1. On transfer, latch the pair -> MUL_REQ.
- MUL_REQ: mult_stb=1, mult_a/mult_b = latched pair. On mult_ack -> MUL_WAIT.
- MUL_WAIT: on mult_z_stb, capture product.
  - If count==0: accumulator=product, no adder pass, -> NEXT.
  - Else -> ADD_REQ.
- ADD_REQ: add_stb=1, add_a=accumulator, add_b=product. On add_ack -> ADD_WAIT.
- ADD_WAIT: on add_z_stb, accumulator=add_z -> NEXT.
- NEXT: count+1.
  - If count+1 == length -> DONE.
  - Else -> GET.
- DONE: result=accumulator, result_valid=1 from the cycle after entry. Hold until result_valid&result_ready at a posedge, then -> IDLE; result_valid=0 the next cycle.
- Sequencing constraints:
  - Exactly one FPU operation in flight; mult_stb and add_stb are never both high.
  - elem_ready is high only in GET.
  - start while busy=1 is ignored.
- Arithmetic: the block does no FP math itself; values pass bit-exact. NaN/Inf propagate unchanged.
- Latency with zero-wait FPU acks: bounded by the FPU cores.
- The block tolerates arbitrary ack/stb delays, including an ack arriving in the same cycle the strobe rises.

Test Plan:
- Reset then idle: hold rst=0 for 10 cycles, release -> all outputs 0, busy=0; elem_valid=1 with no start -> elem_ready stays 0.
- vec_len=2, pairs (0x3F800000, 0x40400000) and (0x40000000, 0x40800000) [1*3 + 2*4] -> exactly 2 mult handshakes, 1 add handshake with add_a=0x40400000 and add_b=0x41000000; result=0x41300000 (11.0), result_valid=1.
- vec_len=1, pair (0x40000000, 0x40800000) -> one multiply, no add_stb; result=0x41000000.
- vec_len=0 start -> no FPU strobes; result=0x00000000, result_valid=1 within 2 cycles; result_ready=0 for 5 cycles -> result_valid held and result stable.
- Random FPU delays: bench model delays ack/z_stb by 0-7 cycles; vec_len=16, all pairs (1.0, 1.0) -> result=0x41800000 (16.0); mult_stb and add_stb never concurrent; each *_z_ack exactly 1 cycle wide.
- Reset mid-operation: assert rst=0 while in ADD_WAIT -> next cycle all strobes/acks 0, busy=0; a new vec_len=1 run (1.0*1.0) returns 0x3F800000 with no leftover sum.

Source files
------------

// File: rtl/fpu_dot_sequencer_if.sv
// rtl/fpu_dot_sequencer_if.sv - operand, FPU strobe/ack and result signals of the dot-product sequencer
interface fpu_dot_sequencer_if #(parameter int LEN_W = 5);
  logic             start;
  logic [LEN_W-1:0] vec_len;
  logic [31:0]      elem_a;
  logic [31:0]      elem_b;
  logic             elem_valid;
  logic             elem_ready;

  logic [31:0]      mult_a;
  logic [31:0]      mult_b;
  logic             mult_stb;
  logic             mult_ack;
  logic [31:0]      mult_z;
  logic             mult_z_stb;
  logic             mult_z_ack;

  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic             add_stb;
  logic             add_ack;
  logic [31:0]      add_z;
  logic             add_z_stb;
  logic             add_z_ack;

  logic [31:0]      result;
  logic             result_valid;
  logic             result_ready;
  logic             busy;

  modport master (
    input  start, vec_len, elem_a, elem_b, elem_valid,
    input  mult_ack, mult_z, mult_z_stb,
    input  add_ack, add_z, add_z_stb,
    input  result_ready,
    output elem_ready,
    output mult_a, mult_b, mult_stb, mult_z_ack,
    output add_a, add_b, add_stb, add_z_ack,
    output result, result_valid, busy
  );

  modport slave (
    output start, vec_len, elem_a, elem_b, elem_valid,
    output mult_ack, mult_z, mult_z_stb,
    output add_ack, add_z, add_z_stb,
    output result_ready,
    input  elem_ready,
    input  mult_a, mult_b, mult_stb, mult_z_ack,
    input  add_a, add_b, add_stb, add_z_ack,
    input  result, result_valid, busy
  );
endinterface

// File: rtl/fpu_dot_sequencer.sv
// rtl/fpu_dot_sequencer.sv - chains FPU multiply/add handshakes into one dot product per start
module fpu_dot_sequencer #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input logic                clk,
  input logic                rst,
  fpu_dot_sequencer_if.master dp
);

  typedef enum logic [2:0] {
    IDLE, GET, MUL_REQ, MUL_WAIT, ADD_REQ, ADD_WAIT, NEXT, DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] count_inc;
  logic [LEN_W-1:0] len_clamp;
  logic [31:0]      pair_a;
  logic [31:0]      pair_b;
  logic [31:0]      prod;
  logic [31:0]      acc;
  logic [31:0]      result_q;
  logic             result_valid_q;
  logic             mult_z_ack_q;
  logic             add_z_ack_q;
  logic             elem_ready_c;
  logic             mult_stb_c;
  logic             add_stb_c;
  logic             busy_c;

  assign len_clamp = (dp.vec_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : dp.vec_len;
  assign count_inc = count + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      len            <= '0;
      count          <= '0;
      pair_a         <= '0;
      pair_b         <= '0;
      prod           <= '0;
      acc            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      mult_z_ack_q   <= 1'b0;
      add_z_ack_q    <= 1'b0;
    end else begin
      state        <= state_next;
      mult_z_ack_q <= 1'b0;
      add_z_ack_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (dp.start) begin
            len   <= len_clamp;
            count <= '0;
            acc   <= '0;
          end
        end
        GET: begin
          if (dp.elem_valid) begin
            pair_a <= dp.elem_a;
            pair_b <= dp.elem_b;
          end
        end
        MUL_WAIT: begin
          if (dp.mult_z_stb) begin
            prod         <= dp.mult_z;
            mult_z_ack_q <= 1'b1;
            // First product seeds the sum directly instead of adding to zero.
            if (count == '0) begin
              acc <= dp.mult_z;
            end
          end
        end
        ADD_WAIT: begin
          if (dp.add_z_stb) begin
            acc         <= dp.add_z;
            add_z_ack_q <= 1'b1;
          end
        end
        NEXT: begin
          count <= count_inc;
        end
        DONE: begin
          result_q <= acc;
          if (result_valid_q && dp.result_ready) begin
            result_valid_q <= 1'b0;
          end else begin
            result_valid_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (dp.start) begin
          state_next = (len_clamp == '0) ? DONE : GET;
        end
      end
      GET: begin
        if (dp.elem_valid) begin
          state_next = MUL_REQ;
        end
      end
      MUL_REQ: begin
        if (dp.mult_ack) begin
          state_next = MUL_WAIT;
        end
      end
      MUL_WAIT: begin
        if (dp.mult_z_stb) begin
          state_next = (count == '0) ? NEXT : ADD_REQ;
        end
      end
      ADD_REQ: begin
        if (dp.add_ack) begin
          state_next = ADD_WAIT;
        end
      end
      ADD_WAIT: begin
        if (dp.add_z_stb) begin
          state_next = NEXT;
        end
      end
      NEXT: begin
        state_next = (count_inc == len) ? DONE : GET;
      end
      DONE: begin
        // Leave only once the registered valid has actually been seen.
        if (result_valid_q && dp.result_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    elem_ready_c = 1'b0;
    mult_stb_c   = 1'b0;
    add_stb_c    = 1'b0;
    busy_c       = 1'b1;
    case (state)
      IDLE:    busy_c       = 1'b0;
      GET:     elem_ready_c = 1'b1;
      MUL_REQ: mult_stb_c   = 1'b1;
      ADD_REQ: add_stb_c    = 1'b1;
      default: begin
      end
    endcase
  end

  assign dp.elem_ready   = elem_ready_c;
  assign dp.mult_stb     = mult_stb_c;
  assign dp.add_stb      = add_stb_c;
  assign dp.busy         = busy_c;
  assign dp.mult_a       = pair_a;
  assign dp.mult_b       = pair_b;
  assign dp.mult_z_ack   = mult_z_ack_q;
  assign dp.add_a        = acc;
  assign dp.add_b        = prod;
  assign dp.add_z_ack    = add_z_ack_q;
  assign dp.result       = result_q;
  assign dp.result_valid = result_valid_q;

endmodule

// File: tb/tb_fpu_dot_sequencer.sv
// tb/tb_fpu_dot_sequencer.sv - randomized bench with integer-valued FPU models and a dot-product reference
module tb_fpu_dot_sequencer;
  logic clk;
  logic rst;

  fpu_dot_sequencer_if #(.LEN_W(5)) bus();

  fpu_dot_sequencer #(.MAX_LEN(16), .LEN_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .dp  (bus)
  );

  int          n_cmp;
  int          n_fail;
  int          max_dly;
  bit          add_hold;
  int unsigned mult_hs;
  int unsigned add_hs;
  logic [31:0] add_log_a[$];
  logic [31:0] add_log_b[$];
  int unsigned conc_viol;
  int unsigned zack_viol;
  int unsigned mz_pulses;
  int unsigned az_pulses;
  int unsigned va[16];
  int unsigned vb[16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Exact conversions for non-negative integers below 2**24.
  function automatic logic [31:0] int_to_f32(input int unsigned v);
    int          p;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 24; i++) if (v[i]) p = i;
    m = v << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int unsigned f32_to_int(input logic [31:0] f);
    int          e;
    logic [31:0] m;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]) - 127;
    if (e < 0 || e > 23) return 0;
    m = {9'h0, 1'b1, f[22:0]};
    return m >> (23 - e);
  endfunction

  // Multiplier model: ack and result strobe each after 0..max_dly cycles.
  initial begin
    int          ph;
    int          dly;
    logic [31:0] res;
    bus.mult_ack = 1'b0; bus.mult_z_stb = 1'b0; bus.mult_z = 32'h0;
    ph = 0; dly = 0; res = 32'h0; mult_hs = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bus.mult_ack = 1'b0; bus.mult_z_stb = 1'b0; ph = 0;
      end else begin
        case (ph)
          0: if (bus.mult_stb) begin
            dly = $urandom_range(max_dly, 0);
            ph = 1;
            if (dly == 0) begin
              bus.mult_ack = 1'b1; mult_hs++; ph = 2;
              res = int_to_f32(f32_to_int(bus.mult_a) * f32_to_int(bus.mult_b));
            end
          end
          1: begin
            dly--;
            if (dly <= 0) begin
              bus.mult_ack = 1'b1; mult_hs++; ph = 2;
              res = int_to_f32(f32_to_int(bus.mult_a) * f32_to_int(bus.mult_b));
            end
          end
          2: begin
            bus.mult_ack = 1'b0;
            dly = $urandom_range(max_dly, 0);
            ph = 3;
            if (dly == 0) begin bus.mult_z = res; bus.mult_z_stb = 1'b1; ph = 4; end
          end
          3: begin
            if (dly > 0) dly--;
            if (dly == 0) begin bus.mult_z = res; bus.mult_z_stb = 1'b1; ph = 4; end
          end
          default: if (bus.mult_z_ack) begin bus.mult_z_stb = 1'b0; ph = 0; end
        endcase
      end
    end
  end

  // Adder model: same timing, logs operands, can withhold its result.
  initial begin
    int          ph;
    int          dly;
    logic [31:0] res;
    bus.add_ack = 1'b0; bus.add_z_stb = 1'b0; bus.add_z = 32'h0;
    ph = 0; dly = 0; res = 32'h0; add_hs = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bus.add_ack = 1'b0; bus.add_z_stb = 1'b0; ph = 0;
      end else begin
        case (ph)
          0: if (bus.add_stb) begin
            dly = $urandom_range(max_dly, 0);
            ph = 1;
            if (dly == 0) begin
              bus.add_ack = 1'b1; add_hs++; ph = 2;
              add_log_a.push_back(bus.add_a); add_log_b.push_back(bus.add_b);
              res = int_to_f32(f32_to_int(bus.add_a) + f32_to_int(bus.add_b));
            end
          end
          1: begin
            dly--;
            if (dly <= 0) begin
              bus.add_ack = 1'b1; add_hs++; ph = 2;
              add_log_a.push_back(bus.add_a); add_log_b.push_back(bus.add_b);
              res = int_to_f32(f32_to_int(bus.add_a) + f32_to_int(bus.add_b));
            end
          end
          2: begin
            bus.add_ack = 1'b0;
            dly = $urandom_range(max_dly, 0);
            ph = 3;
            if (dly == 0 && !add_hold) begin bus.add_z = res; bus.add_z_stb = 1'b1; ph = 4; end
          end
          3: begin
            if (dly > 0) dly--;
            if (dly == 0 && !add_hold) begin bus.add_z = res; bus.add_z_stb = 1'b1; ph = 4; end
          end
          default: if (bus.add_z_ack) begin bus.add_z_stb = 1'b0; ph = 0; end
        endcase
      end
    end
  end

  // Protocol monitor sampled just after each rising edge.
  initial begin
    bit prev_mz;
    bit prev_az;
    prev_mz = 0; prev_az = 0;
    conc_viol = 0; zack_viol = 0; mz_pulses = 0; az_pulses = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        prev_mz = 0; prev_az = 0;
      end else begin
        if (bus.mult_stb && bus.add_stb) conc_viol++;
        if (prev_mz && bus.mult_z_ack) zack_viol++;
        if (prev_az && bus.add_z_ack) zack_viol++;
        if (bus.mult_z_ack && !prev_mz) mz_pulses++;
        if (bus.add_z_ack && !prev_az) az_pulses++;
        prev_mz = bus.mult_z_ack;
        prev_az = bus.add_z_ack;
      end
    end
  end

  task automatic start_dot(input int len);
    bus.start   = 1'b1;
    bus.vec_len = 5'(len);
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic feed_pairs(input int n, output bit to);
    int w;
    to = 0;
    for (int i = 0; i < n; i++) begin
      bus.elem_a     = int_to_f32(va[i]);
      bus.elem_b     = int_to_f32(vb[i]);
      bus.elem_valid = 1'b1;
      w = 0;
      while (!bus.elem_ready && w < 400) begin @(negedge clk); w++; end
      if (w >= 400) begin to = 1; break; end
      @(negedge clk);
    end
    bus.elem_valid = 1'b0;
  endtask

  task automatic wait_result(input int hold, output logic [31:0] res, output bit to,
                             output int wcyc, output bit stable, output bit dropped);
    logic [31:0] r0;
    wcyc = 0; to = 0; stable = 1; dropped = 0;
    while (!bus.result_valid && wcyc < 3000) begin @(negedge clk); wcyc++; end
    if (wcyc >= 3000) begin to = 1; res = 32'hx; return; end
    res = bus.result;
    r0  = bus.result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.result_valid || bus.result !== r0) stable = 0;
    end
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    dropped = !bus.result_valid && !bus.busy;
  endtask

  task automatic run_dot(input int len, input int n_feed, input int hold,
                         output logic [31:0] res, output bit to, output int wcyc,
                         output bit stable, output bit dropped);
    bit fto;
    start_dot(len);
    feed_pairs(n_feed, fto);
    wait_result(hold, res, to, wcyc, stable, dropped);
    to = to | fto;
  endtask

  function automatic logic [31:0] ref_dot(input int n);
    int unsigned s;
    s = 0;
    for (int i = 0; i < n; i++) s += va[i] * vb[i];
    return int_to_f32(s);
  endfunction

  task automatic test_reset();
    bit leak;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.elem_ready, bus.mult_stb, bus.mult_z_ack, bus.add_stb, bus.add_z_ack,
         bus.result_valid, bus.busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000000", {bus.elem_ready, bus.mult_stb,
               bus.mult_z_ack, bus.add_stb, bus.add_z_ack, bus.result_valid, bus.busy});
    end
    n_cmp++;
    if ({bus.result, bus.mult_a, bus.mult_b, bus.add_a, bus.add_b} !== 160'h0) begin
      n_fail++;
      $display("FAIL reset_data: result=%h mult_a=%h mult_b=%h add_a=%h add_b=%h want all 0",
               bus.result, bus.mult_a, bus.mult_b, bus.add_a, bus.add_b);
    end
    leak = 0;
    bus.elem_valid = 1'b1;
    repeat (5) begin @(negedge clk); if (bus.elem_ready || bus.busy) leak = 1; end
    bus.elem_valid = 1'b0;
    n_cmp++;
    if (leak !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_elem_ready: elem_ready/busy rose without start, want 0");
    end
  endtask

  task automatic test_two_elem();
    logic [31:0] res; bit to, st, dr; int wc;
    int unsigned m0, a0;
    max_dly = 0;
    va[0] = 1; vb[0] = 3; va[1] = 2; vb[1] = 4;
    m0 = mult_hs; a0 = add_hs;
    add_log_a.delete(); add_log_b.delete();
    run_dot(2, 2, 0, res, to, wc, st, dr);
    n_cmp++;
    if (to || res !== 32'h41300000) begin
      n_fail++; $display("FAIL two_elem_result: got %h timeout=%0d want 41300000", res, to);
    end
    n_cmp++;
    if (mult_hs - m0 !== 2 || add_hs - a0 !== 1) begin
      n_fail++; $display("FAIL two_elem_handshakes: mult=%0d add=%0d want 2/1", mult_hs - m0, add_hs - a0);
    end
    n_cmp++;
    if (add_log_a.size() != 1 || add_log_a[0] !== 32'h40400000 || add_log_b[0] !== 32'h41000000) begin
      n_fail++;
      $display("FAIL two_elem_add_ops: n=%0d a=%h b=%h want 40400000/41000000",
               add_log_a.size(), add_log_a.size() ? add_log_a[0] : 32'h0,
               add_log_b.size() ? add_log_b[0] : 32'h0);
    end
    n_cmp++;
    if (dr !== 1'b1) begin
      n_fail++; $display("FAIL two_elem_release: result_valid/busy still high after accept, want 0");
    end
  endtask

  task automatic test_single();
    logic [31:0] res; bit to, st, dr; int wc;
    int unsigned m0, a0;
    va[0] = 2; vb[0] = 4;
    m0 = mult_hs; a0 = add_hs;
    run_dot(1, 1, 0, res, to, wc, st, dr);
    n_cmp++;
    if (to || res !== 32'h41000000 || mult_hs - m0 !== 1 || add_hs - a0 !== 0) begin
      n_fail++;
      $display("FAIL single_elem: got %h mult=%0d add=%0d want 41000000 1/0", res, mult_hs - m0, add_hs - a0);
    end
  endtask

  task automatic test_zero_len();
    logic [31:0] res; bit to, st, dr; int wc;
    int unsigned m0, a0;
    m0 = mult_hs; a0 = add_hs;
    run_dot(0, 0, 5, res, to, wc, st, dr);
    n_cmp++;
    if (to || res !== 32'h0 || wc > 2) begin
      n_fail++; $display("FAIL zero_len_result: got %h after %0d cycles want 00000000 within 2", res, wc);
    end
    n_cmp++;
    if (st !== 1'b1 || mult_hs != m0 || add_hs != a0) begin
      n_fail++;
      $display("FAIL zero_len_hold: stable=%0d mult=%0d add=%0d want 1/0/0", st, mult_hs - m0, add_hs - a0);
    end
  endtask

  task automatic test_random_delay();
    logic [31:0] res; bit to, st, dr; int wc;
    int unsigned mp0, ap0;
    max_dly = 7;
    for (int i = 0; i < 16; i++) begin va[i] = 1; vb[i] = 1; end
    conc_viol = 0; zack_viol = 0;
    mp0 = mz_pulses; ap0 = az_pulses;
    run_dot(16, 16, 0, res, to, wc, st, dr);
    n_cmp++;
    if (to || res !== 32'h41800000) begin
      n_fail++; $display("FAIL rand_delay_result: got %h want 41800000", res);
    end
    n_cmp++;
    if (conc_viol != 0 || zack_viol != 0) begin
      n_fail++; $display("FAIL rand_delay_protocol: concurrent=%0d wide_zack=%0d want 0/0", conc_viol, zack_viol);
    end
    n_cmp++;
    if (mz_pulses - mp0 != 16 || az_pulses - ap0 != 15) begin
      n_fail++;
      $display("FAIL rand_delay_zack_count: mult=%0d add=%0d want 16/15", mz_pulses - mp0, az_pulses - ap0);
    end
  endtask

  task automatic test_random_vectors();
    logic [31:0] res; bit to, st, dr; int wc;
    int len;
    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(16, 1);
      max_dly = $urandom_range(7, 0);
      for (int i = 0; i < 16; i++) begin va[i] = $urandom_range(15, 0); vb[i] = $urandom_range(15, 0); end
      conc_viol = 0;
      run_dot(len, len, $urandom_range(3, 0), res, to, wc, st, dr);
      n_cmp++;
      if (to || res !== ref_dot(len) || conc_viol != 0 || !st) begin
        n_fail++;
        $display("FAIL rand_vec[%0d]: len=%0d got %h want %h concurrent=%0d", t, len, res, ref_dot(len), conc_viol);
      end
    end
  endtask

  task automatic test_clamp();
    logic [31:0] res; bit to, st, dr; int wc;
    int unsigned m0;
    max_dly = 2;
    for (int i = 0; i < 16; i++) begin va[i] = $urandom_range(15, 0); vb[i] = $urandom_range(15, 0); end
    m0 = mult_hs;
    run_dot(20, 16, 0, res, to, wc, st, dr);
    n_cmp++;
    if (to || res !== ref_dot(16) || mult_hs - m0 != 16 || !dr) begin
      n_fail++;
      $display("FAIL clamp_len: got %h mult=%0d want %h 16", res, mult_hs - m0, ref_dot(16));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; bit to, fto, st, dr; int wc;
    int unsigned m0;
    bit extra;
    max_dly = 1;
    va[0] = 3; vb[0] = 5; va[1] = 7; vb[1] = 2;
    m0 = mult_hs;
    start_dot(2);
    start_dot(0);
    feed_pairs(2, fto);
    wait_result(0, res, to, wc, st, dr);
    n_cmp++;
    if (to || fto || res !== ref_dot(2) || mult_hs - m0 != 2) begin
      n_fail++; $display("FAIL busy_start_ignored: got %h mult=%0d want %h 2", res, mult_hs - m0, ref_dot(2));
    end
    extra = 0;
    repeat (4) begin @(negedge clk); if (bus.busy || bus.result_valid) extra = 1; end
    n_cmp++;
    if (extra !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_leftover: block restarted from an ignored start, want idle");
    end
    va[0] = 6; vb[0] = 6;
    run_dot(1, 1, 0, res, to, wc, st, dr);
    n_cmp++;
    if (to || res !== int_to_f32(36)) begin
      n_fail++; $display("FAIL back_to_back: got %h want %h", res, int_to_f32(36));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; bit to, fto, st, dr; int wc;
    int unsigned a0;
    int w;
    max_dly = 0;
    add_hold = 1;
    va[0] = 5; vb[0] = 5; va[1] = 3; vb[1] = 3;
    a0 = add_hs;
    start_dot(2);
    feed_pairs(2, fto);
    w = 0;
    while (add_hs == a0 && w < 200) begin @(negedge clk); w++; end
    n_cmp++;
    if (fto || w >= 200) begin
      n_fail++; $display("FAIL reset_mid_reach: adder handshake not seen after %0d cycles", w);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.mult_stb, bus.add_stb, bus.mult_z_ack, bus.add_z_ack, bus.busy, bus.elem_ready,
         bus.result_valid} !== 7'b0 || bus.result !== 32'h0 || bus.add_a !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_abort: ctrl=%b result=%h add_a=%h want 0", {bus.mult_stb, bus.add_stb,
               bus.mult_z_ack, bus.add_z_ack, bus.busy, bus.elem_ready, bus.result_valid}, bus.result, bus.add_a);
    end
    repeat (3) @(negedge clk);
    add_hold = 0;
    rst = 1'b1;
    @(negedge clk);
    va[0] = 1; vb[0] = 1;
    a0 = add_hs;
    run_dot(1, 1, 0, res, to, wc, st, dr);
    n_cmp++;
    if (to || res !== 32'h3F800000 || add_hs != a0) begin
      n_fail++; $display("FAIL reset_mid_rerun: got %h add=%0d want 3f800000 0", res, add_hs - a0);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    max_dly = 0; add_hold = 0;
    rst = 1'b0;
    bus.start = 1'b0; bus.vec_len = '0;
    bus.elem_a = 32'h0; bus.elem_b = 32'h0; bus.elem_valid = 1'b0;
    bus.result_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_two_elem();
    test_single();
    test_zero_len();
    test_random_delay();
    test_random_vectors();
    test_clamp();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
